// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: word-wide data-memory request/response handshake.
interface mem_wb_stage_if #(parameter int DPW = 32);
  logic dmem_valid, dmem_ready, dmem_we, dmem_rvalid;
  logic [DPW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  modport master (output dmem_valid, dmem_we, dmem_addr, dmem_wdata,
                  input  dmem_ready, dmem_rvalid, dmem_rdata);
  modport slave  (input  dmem_valid, dmem_we, dmem_addr, dmem_wdata,
                  output dmem_ready, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: rv32i M->W stage; runs word data-memory accesses and drives the W pipeline register.
module mem_wb_stage #(
  parameter int DPW = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           regwriteM,
  input  logic           resultsrcM,
  input  logic           memwriteM,
  input  logic [DPW-1:0] aluresultM,
  input  logic [DPW-1:0] Rd2M,
  input  logic [4:0]     RdM,
  output logic           stallM,
  mem_wb_stage_if.master dmem,
  output logic           regwriteW,
  output logic [4:0]     RdW,
  output logic [DPW-1:0] resultW,
  output logic           dmem_err
);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  state_t         r_state, w_next;
  logic [7:0]     r_cnt;
  logic [DPW-1:0] r_addr, r_wdata, r_result_w;
  logic [4:0]     r_rd, r_rd_w;
  logic           r_we, r_rw, r_regwrite_w, r_err;
  logic           w_memop, w_misal, w_issue, w_alu, w_load_done, w_done, w_tmo;
  assign w_memop     = memwriteM | resultsrcM;
  assign w_misal     = w_memop & (aluresultM[1:0] != 2'b00);
  assign w_issue     = (r_state == IDLE) & w_memop & ~w_misal;
  assign w_alu       = (r_state == IDLE) & ~w_memop;
  assign w_load_done = (r_state == RSP) & dmem.dmem_rvalid;
  always_comb begin
    w_done = ((r_state == REQ) & dmem.dmem_ready & r_we) | w_load_done;
    w_tmo  = (r_state != IDLE) & ~w_done & (r_cnt == CNT_LAST);
    w_next = (w_done | w_tmo) ? IDLE :
             w_issue ? REQ :
             ((r_state == REQ) & dmem.dmem_ready) ? RSP : r_state;
    // stall exactly while the access is still in flight after this edge
    stallM = ~rst & (w_next != IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_rd         <= '0;
      r_rw         <= 1'b0;
      r_regwrite_w <= 1'b0;
      r_rd_w       <= '0;
      r_result_w   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= (r_state == IDLE) ? 8'd0 : r_cnt + 8'd1;
      r_err        <= ((r_state == IDLE) & w_misal) | w_tmo;
      r_regwrite_w <= w_alu ? regwriteM : w_load_done ? r_rw : 1'b0;
      if (w_issue) begin
        r_addr  <= aluresultM;
        r_wdata <= Rd2M;
        r_we    <= memwriteM;
        r_rd    <= RdM;
        r_rw    <= regwriteM;
      end
      if (w_alu) begin
        r_rd_w     <= RdM;
        r_result_w <= aluresultM;
      end else if (w_load_done) begin
        r_rd_w     <= r_rd;
        r_result_w <= dmem.dmem_rdata;
      end
    end
  end
  assign dmem.dmem_valid = (r_state == REQ);
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;
  assign regwriteW       = r_regwrite_w;
  assign RdW             = r_rd_w;
  assign resultW         = r_result_w;
  assign dmem_err        = r_err;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vector table plus hand-written multi-cycle sequences for mem_wb_stage.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic regwriteM, resultsrcM, memwriteM, stallM, regwriteW, dmem_err;
  logic [31:0] aluresultM, Rd2M, resultW;
  logic [4:0] RdM, RdW;
  int checks = 0;
  int errors = 0;
  int beats, stalls;
  mem_wb_stage_if #(.DPW(32)) dif ();
  mem_wb_stage #(.DPW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .regwriteM(regwriteM), .resultsrcM(resultsrcM),
    .memwriteM(memwriteM), .aluresultM(aluresultM), .Rd2M(Rd2M), .RdM(RdM),
    .stallM(stallM), .dmem(dif), .regwriteW(regwriteW), .RdW(RdW),
    .resultW(resultW), .dmem_err(dmem_err));
  always #5 clk = ~clk;
  typedef struct {
    logic rw, rs, mw;
    logic [31:0] alu;
    logic [4:0] rd;
    logic stall, exp_rw;
    logic [4:0] exp_rd;
    logic [31:0] exp_res;
    logic exp_err;
  } vec_t;
  vec_t vt [7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic rw, input logic rs, input logic mw, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd);
    regwriteM = rw; resultsrcM = rs; memwriteM = mw; aluresultM = alu; Rd2M = wd; RdM = rd;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7);
    dif.dmem_ready = 1'b0; dif.dmem_rvalid = 1'b0; dif.dmem_rdata = '0;
    #12;
    chk("rst_stall", {31'd0, stallM}, 32'd0);
    chk("rst_valid", {31'd0, dif.dmem_valid}, 32'd0);
    chk("rst_we", {31'd0, dif.dmem_we}, 32'd0);
    chk("rst_addr", dif.dmem_addr, 32'd0);
    chk("rst_wdata", dif.dmem_wdata, 32'd0);
    chk("rst_regwriteW", {31'd0, regwriteW}, 32'd0);
    chk("rst_RdW", {27'd0, RdW}, 32'd0);
    chk("rst_resultW", resultW, 32'd0);
    chk("rst_err", {31'd0, dmem_err}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst = 1'b0;
    tick();
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h1234,     5'd5,  1'b0, 1'b1, 5'd5,  32'h1234,     1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 32'hAAAA5555, 5'd9,  1'b0, 1'b0, 5'd9,  32'hAAAA5555, 1'b0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 32'h42,       5'd7,  1'b0, 1'b0, 5'd9,  32'hAAAA5555, 1'b1};
    vt[3] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 5'd31, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0};
    vt[4] = '{1'b1, 1'b0, 1'b1, 32'h103,      5'd3,  1'b0, 1'b0, 5'd31, 32'hFFFFFFFF, 1'b1};
    vt[5] = '{1'b1, 1'b1, 1'b1, 32'h1,        5'd2,  1'b0, 1'b0, 5'd31, 32'hFFFFFFFF, 1'b1};
    vt[6] = '{1'b1, 1'b0, 1'b0, 32'h0,        5'd0,  1'b0, 1'b1, 5'd0,  32'h0,        1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].rw, vt[i].rs, vt[i].mw, vt[i].alu, 32'h0, vt[i].rd);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, stallM}, {31'd0, vt[i].stall});
      chk($sformatf("v%0d_valid", i), {31'd0, dif.dmem_valid}, 32'd0);
      tick();
      chk($sformatf("v%0d_regwriteW", i), {31'd0, regwriteW}, {31'd0, vt[i].exp_rw});
      chk($sformatf("v%0d_RdW", i), {27'd0, RdW}, {27'd0, vt[i].exp_rd});
      chk($sformatf("v%0d_resultW", i), resultW, vt[i].exp_res);
      chk($sformatf("v%0d_err", i), {31'd0, dmem_err}, {31'd0, vt[i].exp_err});
      chk($sformatf("v%0d_valid_after", i), {31'd0, dif.dmem_valid}, 32'd0);
    end
    // store held off by ready for three cycles; completes in the cycle the counter hits its limit
    drive(1'b1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 5'd4);
    #1;
    chk("st_idle_stall", {31'd0, stallM}, 32'd1);
    stalls = 1; beats = 0;
    tick();
    for (int k = 0; k < 4; k++) begin
      dif.dmem_ready = (k == 3);
      #1;
      chk($sformatf("st%0d_valid", k), {31'd0, dif.dmem_valid}, 32'd1);
      chk($sformatf("st%0d_addr", k), dif.dmem_addr, 32'h100);
      chk($sformatf("st%0d_wdata", k), dif.dmem_wdata, 32'hDEADBEEF);
      chk($sformatf("st%0d_we", k), {31'd0, dif.dmem_we}, 32'd1);
      chk($sformatf("st%0d_stall", k), {31'd0, stallM}, {31'd0, k != 3});
      if (stallM) stalls++;
      if (dif.dmem_valid && dif.dmem_ready) beats++;
      tick();
      chk($sformatf("st%0d_regwriteW", k), {31'd0, regwriteW}, 32'd0);
    end
    dif.dmem_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("st_stall_cycles", stalls, 4);
    chk("st_beats", beats, 1);
    chk("st_valid_done", {31'd0, dif.dmem_valid}, 32'd0);
    chk("st_err", {31'd0, dmem_err}, 32'd0);
    tick();
    // load: ready immediately, rvalid two cycles later
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7);
    #1;
    chk("ld_idle_stall", {31'd0, stallM}, 32'd1);
    tick();
    dif.dmem_ready = 1'b1;
    #1;
    chk("ld_req_valid", {31'd0, dif.dmem_valid}, 32'd1);
    chk("ld_req_addr", dif.dmem_addr, 32'h40);
    chk("ld_req_we", {31'd0, dif.dmem_we}, 32'd0);
    chk("ld_req_stall", {31'd0, stallM}, 32'd1);
    tick();
    dif.dmem_ready = 1'b0;
    #1;
    chk("ld_rsp_valid", {31'd0, dif.dmem_valid}, 32'd0);
    chk("ld_rsp_stall", {31'd0, stallM}, 32'd1);
    chk("ld_rsp_bubble", {31'd0, regwriteW}, 32'd0);
    tick();
    dif.dmem_rvalid = 1'b1; dif.dmem_rdata = 32'hCAFEF00D;
    #1;
    chk("ld_rvalid_stall", {31'd0, stallM}, 32'd0);
    tick();
    dif.dmem_rvalid = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("ld_regwriteW", {31'd0, regwriteW}, 32'd1);
    chk("ld_RdW", {27'd0, RdW}, 32'd7);
    chk("ld_resultW", resultW, 32'hCAFEF00D);
    chk("ld_err", {31'd0, dmem_err}, 32'd0);
    tick();
    // load that never sees rvalid: aborted on the fourth REQ/RSP cycle
    drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd8);
    tick();
    for (int k = 0; k < 4; k++) begin
      dif.dmem_ready = (k == 0);
      #1;
      chk($sformatf("to%0d_stall", k), {31'd0, stallM}, {31'd0, k != 3});
      tick();
      chk($sformatf("to%0d_regwriteW", k), {31'd0, regwriteW}, 32'd0);
    end
    dif.dmem_ready = 1'b0;
    chk("to_err", {31'd0, dmem_err}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h77, 32'h0, 5'd8);
    dif.dmem_rvalid = 1'b1; dif.dmem_rdata = 32'h5555;
    #1;
    chk("to_idle_stall", {31'd0, stallM}, 32'd0);
    chk("to_idle_valid", {31'd0, dif.dmem_valid}, 32'd0);
    tick();
    dif.dmem_rvalid = 1'b0;
    chk("to_err_pulse", {31'd0, dmem_err}, 32'd0);
    chk("to_stray_regwriteW", {31'd0, regwriteW}, 32'd0);
    chk("to_stray_resultW", resultW, 32'h77);
    // reset while waiting in RSP
    drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd10);
    tick();
    dif.dmem_ready = 1'b1;
    tick();
    dif.dmem_ready = 1'b0;
    #1;
    chk("rr_in_rsp_stall", {31'd0, stallM}, 32'd1);
    rst = 1'b1;
    dif.dmem_rvalid = 1'b1; dif.dmem_rdata = 32'hBAD0BAD0;
    #1;
    chk("rr_valid", {31'd0, dif.dmem_valid}, 32'd0);
    chk("rr_stall", {31'd0, stallM}, 32'd0);
    chk("rr_regwriteW", {31'd0, regwriteW}, 32'd0);
    chk("rr_RdW", {27'd0, RdW}, 32'd0);
    chk("rr_resultW", resultW, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h11, 32'h0, 5'd1);
    #1;
    chk("rr_post_stall", {31'd0, stallM}, 32'd0);
    tick();
    dif.dmem_rvalid = 1'b0;
    chk("rr_post_regwriteW", {31'd0, regwriteW}, 32'd0);
    chk("rr_post_resultW", resultW, 32'h11);
    drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd12);
    tick();
    dif.dmem_ready = 1'b1;
    #1;
    chk("rr_new_addr", dif.dmem_addr, 32'h300);
    tick();
    dif.dmem_ready = 1'b0;
    dif.dmem_rvalid = 1'b1; dif.dmem_rdata = 32'h12345678;
    #1;
    chk("rr_new_stall", {31'd0, stallM}, 32'd0);
    tick();
    dif.dmem_rvalid = 1'b0;
    chk("rr_new_regwriteW", {31'd0, regwriteW}, 32'd1);
    chk("rr_new_RdW", {27'd0, RdW}, 32'd12);
    chk("rr_new_resultW", resultW, 32'h12345678);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-to-writeback stage of the rv32i pipeline. It sits directly downstream of the execute/memory pipeline register and consumes its M-stage outputs.
- Runs word-wide data-memory accesses over a valid/ready request and rvalid response handshake. Stalls the upstream stage while an access is outstanding.
- Drives the W-stage pipeline register (regwriteW, RdW, resultW) that feeds register-file writeback and forwarding.

Parameters:
- DPW, 32, datapath width; must match rv32i_pkg::DPW.
- TIMEOUT_CYCLES, 16, maximum cycles spent in REQ+RSP before the access is aborted; legal range 2..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- regwriteM  input  1  M-stage register-write enable.
- resultsrcM  input  1  1 = load (result comes from memory), 0 = ALU result.
- memwriteM  input  1  M-stage store enable.
- aluresultM  input  DPW  ALU result; used as the memory address for loads and stores.
- Rd2M  input  DPW  store data.
- RdM  input  5  destination register.
- stallM  output  1  hold the M-stage register and everything upstream.
- dmem_valid  output  1  request valid.
- dmem_ready  input  1  memory accepts the request.
- dmem_we  output  1  1 = write, 0 = read.
- dmem_addr  output  DPW  word-aligned byte address.
- dmem_wdata  output  DPW  write data.
- dmem_rvalid  input  1  read data valid.
- dmem_rdata  input  DPW  read data.
- regwriteW  output  1  W-stage register-write enable.
- RdW  output  5  W-stage destination register.
- resultW  output  DPW  W-stage writeback value.
- dmem_err  output  1  one-cycle pulse on a misaligned access or a timeout.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; the timeout counter clears.
  - regwriteW=0, RdW=0, resultW=0, dmem_err=0, dmem_valid=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - stallM=0 while rst is high.
- Memory op:
  - memop = memwriteM | resultsrcM.
  - If memwriteM=1, the op is a store, regardless of resultsrcM.
  - A store never writes the register file: the W entry for a store has regwriteW=0.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - Non-memop: stallM=0. The next edge loads W with regwriteM, RdM, resultW=aluresultM. Latency is 1 cycle.
  - Memop with aluresultM[1:0]!=0:
    - No request is issued; dmem_err pulses next cycle; stallM=0.
    - W gets a bubble (regwriteW=0; RdW and resultW hold).
  - Aligned memop:
    - stallM=1; W gets a bubble.
    - Latch addr=aluresultM, wdata=Rd2M, we=memwriteM, RdM and regwriteM.
    - Next state is REQ; the counter clears.
- REQ:
  - dmem_valid=1. dmem_addr, dmem_wdata and dmem_we are taken from the latches and stay stable until ready.
  - stallM=1 except in the completion cycle. A bubble is inserted each stalled cycle.
  - ready and store: stallM=0; W bubble; next state IDLE.
  - ready and load: next state RSP; stallM=1.
  - dmem_rvalid is ignored in REQ.
- RSP:
  - dmem_valid=0, stallM=1.
  - On dmem_rvalid: stallM=0; W gets regwriteW=latched regwrite, RdW=latched Rd, resultW=dmem_rdata; next state IDLE.
- Minimum M-stage occupancy: store 2 cycles, load 3 cycles.
- Timeout:
  - The counter increments each cycle in REQ or RSP.
  - If the counter reaches TIMEOUT_CYCLES-1 without completion: dmem_err pulses the next cycle, stallM=0 that cycle, W gets a bubble, next state IDLE.
  - A late dmem_rvalid that arrives in IDLE is ignored.
- Completion and timeout in the same cycle: completion wins, and dmem_err stays 0.
- When stallM=0, the upstream stage advances at the edge. The same instruction is never re-issued.
- Reset in REQ or RSP:
  - dmem_valid drops immediately; no W write occurs.
  - Responses arriving after reset are ignored.
- Address and data width: DPW. No byte or halfword support; only word accesses are legal.

Test Plan:
- ALU op (regwriteM=1, RdM=5, aluresultM=0x1234, memop=0) -> stallM=0; next cycle regwriteW=1, RdW=5, resultW=0x1234.
- Store to 0x100 with Rd2M=0xDEADBEEF and dmem_ready held 0 for 3 cycles -> dmem_valid held with addr/wdata stable; stallM=1 for 4 cycles then 0 in the ready cycle; regwriteW=0 throughout; exactly one write beat.
- Load from 0x40 to RdM=7 with ready immediate and rvalid 2 cycles later, rdata=0xCAFEF00D -> stallM high until the rvalid cycle; next cycle regwriteW=1, RdW=7, resultW=0xCAFEF00D.
- Load from 0x42 (misaligned) -> no dmem_valid; dmem_err one-cycle pulse; regwriteW=0; stallM=0.
- Load with no rvalid and TIMEOUT_CYCLES=4 -> dmem_err pulse after 4 cycles in REQ/RSP; return to IDLE; a later stray rvalid causes no W write.
- rst asserted while in RSP -> dmem_valid=0 and all W outputs 0 immediately; after release, a new load completes normally; the pre-reset rvalid is ignored.
